// File: rtl/csr_counter_bank_pkg.sv
// Shared definitions for the counter/timer CSR bank: address map, privilege
// encoding and implemented-bit mask helper.
package csr_pkg;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_t;

  localparam int unsigned EVT_SEL_W = 8;
  localparam int unsigned MAX_HPM   = 29;

  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_TIME          = 12'hC01;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_HPMCOUNTER3   = 12'hC03;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
  localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;
  localparam logic [11:0] CSR_SCOUNTEREN    = 12'h106;

  // Bits 0..2 (cycle/time/instret) plus one bit per implemented hpm counter.
  function automatic logic [31:0] impl_mask(int unsigned num_hpm);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i <= 2 || (i >= 3 && i < 3 + num_hpm)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/csr_counter_bank_hpm_counter.sv
// One hardware performance counter: event selector, counter storage and
// sticky overflow flag.
module hpm_counter
  import csr_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 64,
  parameter int unsigned NUM_EVENTS = 8
) (
  input  logic                  phi2,
  input  logic                  rst,
  input  logic                  inhibit,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  wr_cnt,
  input  logic                  wr_evt,
  input  logic [63:0]           data_in,
  output logic [CNT_WIDTH-1:0]  cnt,
  output logic [EVT_SEL_W-1:0]  evt,
  output logic                  of
);

  localparam int unsigned EV_SPAN = 1 << EVT_SEL_W;

  // Selector 0 maps to a constant-zero bit; selectors past NUM_EVENTS land on zero padding.
  logic [EV_SPAN-1:0] ev_ext;
  logic               fire;
  logic               wrap;

  assign ev_ext = EV_SPAN'({events, 1'b0});
  assign fire   = ev_ext[evt] && !inhibit;
  assign wrap   = fire && (&cnt);

  always_ff @(posedge phi2) begin
    if (rst) begin
      cnt <= '0;
      evt <= '0;
      of  <= 1'b0;
    end else begin
      if (wr_cnt)    cnt <= data_in[CNT_WIDTH-1:0];
      else if (fire) cnt <= cnt + CNT_WIDTH'(1);

      if (wr_evt) begin
        evt <= data_in[EVT_SEL_W-1:0];
        of  <= data_in[63];
      end else if (wrap && !wr_cnt) begin
        of  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/csr_counter_bank.sv
// Counter/timer CSR bank: mcycle, minstret, time, mhpmcounters with event
// selectors, mcountinhibit and m/scounteren, with privilege checks.
module csr_counter_bank
  import csr_pkg::*;
#(
  parameter int unsigned NUM_HPM    = 4,
  parameter int unsigned CNT_WIDTH  = 64,
  parameter int unsigned NUM_EVENTS = 8
) (
  input  logic                  phi2,
  input  logic                  rst,
  input  logic                  read,
  input  logic                  write,
  input  logic [1:0]            priv_level,
  input  logic [11:0]           csr_addr,
  input  logic [63:0]           data_in,
  input  logic                  retire,
  input  logic                  time_tick,
  input  logic [NUM_EVENTS-1:0] events,
  output logic [63:0]           data_out,
  output logic                  hit,
  output logic                  invalid,
  output logic                  lcof_irq
);

  localparam logic [31:0] CEN_MASK = impl_mask(NUM_HPM);
  localparam logic [31:0] INH_MASK = CEN_MASK & ~32'h2;

  logic [CNT_WIDTH-1:0] mcycle_q, minstret_q, time_q;
  logic [31:0]          inhibit_q, mcen_q, scen_q;

  logic [CNT_WIDTH-1:0] hpm_cnt [MAX_HPM];
  logic [EVT_SEL_W-1:0] hpm_evt [MAX_HPM];
  logic [MAX_HPM-1:0]   hpm_of;
  logic [MAX_HPM-1:0]   wr_cnt, wr_evt;

  logic [4:0]  idx, hpm_idx;
  logic        in_b, in_c, in_e, is_hpm, gated, wr_ok;
  logic        wr_mcycle, wr_minstret, wr_inhibit, wr_mcen, wr_scen;
  logic [63:0] rd_val;

  always_comb begin
    idx     = csr_addr[4:0];
    hpm_idx = idx - 5'd3;
    in_b    = csr_addr[11:5] == CSR_MCYCLE[11:5];
    in_c    = csr_addr[11:5] == CSR_CYCLE[11:5];
    in_e    = csr_addr[11:5] == CSR_MCOUNTINHIBIT[11:5];
    is_hpm  = idx >= 5'd3;

    hit = (in_b && idx != 5'd1) || in_c || (in_e && (idx == 5'd0 || is_hpm)) ||
          csr_addr == CSR_MCOUNTEREN || csr_addr == CSR_SCOUNTEREN;

    gated = in_c && ((priv_level == PRIV_S && !mcen_q[idx]) ||
                     (priv_level == PRIV_U && !(mcen_q[idx] && scen_q[idx])));

    invalid = hit && (read || write) &&
              (priv_level < csr_addr[9:8] ||
               (write && csr_addr[11:10] == 2'b11) ||
               (read && gated));

    rd_val = '0;
    if (in_b || in_c) begin
      case (idx)
        5'd0:    rd_val = 64'(mcycle_q);
        5'd1:    rd_val = in_c ? 64'(time_q) : '0;
        5'd2:    rd_val = 64'(minstret_q);
        default: rd_val = 64'(hpm_cnt[hpm_idx]);
      endcase
    end else if (in_e) begin
      if (idx == 5'd0)  rd_val = 64'(inhibit_q);
      else if (is_hpm)  rd_val = {hpm_of[hpm_idx], {(63 - EVT_SEL_W){1'b0}}, hpm_evt[hpm_idx]};
    end else if (csr_addr == CSR_MCOUNTEREN) begin
      rd_val = 64'(mcen_q);
    end else if (csr_addr == CSR_SCOUNTEREN) begin
      rd_val = 64'(scen_q);
    end

    data_out = (read && hit && !invalid) ? rd_val : '0;

    wr_ok       = write && hit && !invalid;
    wr_mcycle   = wr_ok && in_b && idx == 5'd0;
    wr_minstret = wr_ok && in_b && idx == 5'd2;
    wr_inhibit  = wr_ok && in_e && idx == 5'd0;
    wr_mcen     = wr_ok && csr_addr == CSR_MCOUNTEREN;
    wr_scen     = wr_ok && csr_addr == CSR_SCOUNTEREN;
    wr_cnt      = '0;
    wr_evt      = '0;
    if (wr_ok && in_b && is_hpm) wr_cnt[hpm_idx] = 1'b1;
    if (wr_ok && in_e && is_hpm) wr_evt[hpm_idx] = 1'b1;
  end

  always_ff @(posedge phi2) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      time_q     <= '0;
      inhibit_q  <= '0;
      mcen_q     <= '0;
      scen_q     <= '0;
    end else begin
      if (wr_mcycle)          mcycle_q <= data_in[CNT_WIDTH-1:0];
      else if (!inhibit_q[0]) mcycle_q <= mcycle_q + CNT_WIDTH'(1);

      if (wr_minstret)                  minstret_q <= data_in[CNT_WIDTH-1:0];
      else if (retire && !inhibit_q[2]) minstret_q <= minstret_q + CNT_WIDTH'(1);

      if (time_tick) time_q <= time_q + CNT_WIDTH'(1);

      if (wr_inhibit) inhibit_q <= data_in[31:0] & INH_MASK;
      if (wr_mcen)    mcen_q    <= data_in[31:0] & CEN_MASK;
      if (wr_scen)    scen_q    <= data_in[31:0] & CEN_MASK;
    end
  end

  // All 29 slots exist so the read mux has a fixed shape; unimplemented ones are tied to zero.
  for (genvar i = 0; i < MAX_HPM; i++) begin : g_hpm
    if (i < NUM_HPM) begin : g_impl
      hpm_counter #(
        .CNT_WIDTH  (CNT_WIDTH),
        .NUM_EVENTS (NUM_EVENTS)
      ) u_hpm (
        .phi2    (phi2),
        .rst     (rst),
        .inhibit (inhibit_q[3+i]),
        .events  (events),
        .wr_cnt  (wr_cnt[i]),
        .wr_evt  (wr_evt[i]),
        .data_in (data_in),
        .cnt     (hpm_cnt[i]),
        .evt     (hpm_evt[i]),
        .of      (hpm_of[i])
      );
    end else begin : g_none
      logic unused_wr;
      assign unused_wr  = wr_cnt[i] ^ wr_evt[i];
      assign hpm_cnt[i] = '0;
      assign hpm_evt[i] = '0;
      assign hpm_of[i]  = 1'b0;
    end
  end

  assign lcof_irq = |hpm_of;

endmodule

// File: tb/tb_csr_counter_bank.sv
// Directed test of csr_counter_bank with 32-bit counters and four hpm counters.
module tb_csr_counter_bank;

  logic        phi2;
  logic        rst;
  logic        read;
  logic        write;
  logic [1:0]  priv_level;
  logic [11:0] csr_addr;
  logic [63:0] data_in;
  logic        retire;
  logic        time_tick;
  logic [7:0]  events;
  logic [63:0] data_out;
  logic        hit;
  logic        invalid;
  logic        lcof_irq;

  int checks = 0;
  int errors = 0;

  logic [63:0] d;
  logic        inv;
  logic        h;

  csr_counter_bank #(
    .NUM_HPM    (4),
    .CNT_WIDTH  (32),
    .NUM_EVENTS (8)
  ) dut (
    .phi2       (phi2),
    .rst        (rst),
    .read       (read),
    .write      (write),
    .priv_level (priv_level),
    .csr_addr   (csr_addr),
    .data_in    (data_in),
    .retire     (retire),
    .time_tick  (time_tick),
    .events     (events),
    .data_out   (data_out),
    .hit        (hit),
    .invalid    (invalid),
    .lcof_irq   (lcof_irq)
  );

  initial begin
    phi2 = 1'b0;
    forever #5 phi2 = ~phi2;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge phi2);
    #1;
  endtask

  task automatic csr_read(input logic [11:0] a, input logic [1:0] p,
                          output logic [63:0] rd, output logic rinv, output logic rhit);
    csr_addr   = a;
    priv_level = p;
    read       = 1'b1;
    #2;
    rd   = data_out;
    rinv = invalid;
    rhit = hit;
    read       = 1'b0;
    priv_level = 2'b11;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [63:0] wd);
    csr_addr   = a;
    data_in    = wd;
    priv_level = 2'b11;
    write      = 1'b1;
    tick();
    write      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; read = 1'b0; write = 1'b0; priv_level = 2'b11;
    csr_addr = '0; data_in = '0; retire = 1'b0; time_tick = 1'b0; events = '0;
    tick(); tick();
    rst = 1'b0;

    check("lcof_after_reset", lcof_irq, 1'b0);
    csr_read(12'hB00, 2'b11, d, inv, h);
    check("mcycle_after_reset", d, 64'd0);
    check("hit_b00", h, 1'b1);
    check("inv_b00_m", inv, 1'b0);
    csr_read(12'hB01, 2'b11, d, inv, h);
    check("hit_b01", h, 1'b0);
    check("data_b01", d, 64'd0);
    csr_addr = 12'hB00; read = 1'b0; #1;
    check("data_no_read", data_out, 64'd0);

    repeat (10) tick();
    csr_read(12'hB00, 2'b11, d, inv, h);
    check("mcycle_10", d, 64'd10);

    time_tick = 1'b1;
    repeat (3) tick();
    time_tick = 1'b0;
    csr_read(12'hC01, 2'b11, d, inv, h);
    check("time_3", d, 64'd3);

    csr_write(12'h320, 64'h1);
    csr_read(12'hB00, 2'b11, d, inv, h);
    check("mcycle_inhibit_a", d, 64'd14);
    repeat (5) tick();
    csr_read(12'hB00, 2'b11, d, inv, h);
    check("mcycle_inhibit_b", d, 64'd14);

    retire = 1'b1;
    repeat (4) tick();
    retire = 1'b0;
    csr_read(12'hB02, 2'b11, d, inv, h);
    check("minstret_4", d, 64'd4);

    csr_write(12'h323, 64'd2);
    csr_read(12'h323, 2'b11, d, inv, h);
    check("mhpmevent3_sel", d, 64'd2);
    events = 8'h02;
    repeat (6) tick();
    events = 8'h01;
    repeat (6) tick();
    events = 8'h00;
    csr_read(12'hB03, 2'b11, d, inv, h);
    check("hpm3_count_6", d, 64'd6);

    csr_write(12'hB03, 64'hFFFF_FFFF);
    events = 8'h02;
    tick();
    events = 8'h00;
    csr_read(12'hB03, 2'b11, d, inv, h);
    check("hpm3_wrap", d, 64'd0);
    csr_read(12'h323, 2'b11, d, inv, h);
    check("mhpmevent3_of", d, 64'h8000_0000_0000_0002);
    check("lcof_set", lcof_irq, 1'b1);
    csr_write(12'h323, 64'd2);
    check("lcof_cleared", lcof_irq, 1'b0);

    csr_write(12'hB03, 64'hFFFF_FFFF);
    events = 8'h02;
    csr_write(12'hB03, 64'd5);
    events = 8'h00;
    csr_read(12'hB03, 2'b11, d, inv, h);
    check("hpm3_write_wins", d, 64'd5);
    check("lcof_write_wins", lcof_irq, 1'b0);

    csr_write(12'hB03, 64'hFFFF_FFFF);
    events = 8'h02;
    csr_write(12'h323, 64'd2);
    events = 8'h00;
    csr_read(12'hB03, 2'b11, d, inv, h);
    check("hpm3_wrap_evt_wr", d, 64'd0);
    check("lcof_evt_wr_wrap", lcof_irq, 1'b0);

    csr_write(12'h320, 64'h9);
    events = 8'h02;
    repeat (3) tick();
    events = 8'h00;
    csr_read(12'hB03, 2'b11, d, inv, h);
    check("hpm3_inhibited", d, 64'd0);

    csr_write(12'h324, 64'd9);
    events = 8'hFF;
    repeat (4) tick();
    events = 8'h00;
    csr_read(12'hB04, 2'b11, d, inv, h);
    check("hpm4_sel_oob", d, 64'd0);
    csr_write(12'h324, 64'd8);
    events = 8'h80;
    repeat (3) tick();
    events = 8'h00;
    csr_read(12'hB04, 2'b11, d, inv, h);
    check("hpm4_sel_8", d, 64'd3);

    csr_write(12'hB07, 64'd55);
    csr_read(12'hB07, 2'b11, d, inv, h);
    check("hpm7_unimpl_data", d, 64'd0);
    check("hpm7_unimpl_inv", inv, 1'b0);

    csr_write(12'h320, 64'h0);
    csr_write(12'hB00, 64'd100);
    csr_read(12'hB00, 2'b11, d, inv, h);
    check("mcycle_write", d, 64'd100);
    tick();
    csr_read(12'hB00, 2'b11, d, inv, h);
    check("mcycle_after_write", d, 64'd101);

    csr_write(12'h306, 64'h1);
    csr_write(12'h106, 64'h0);
    csr_read(12'hC00, 2'b00, d, inv, h);
    check("u_cycle_gated_inv", inv, 1'b1);
    check("u_cycle_gated_data", d, 64'd0);
    csr_write(12'h106, 64'h1);
    csr_read(12'hC00, 2'b00, d, inv, h);
    check("u_cycle_inv", inv, 1'b0);
    check("u_cycle_data", d, 64'd104);
    csr_read(12'hC00, 2'b01, d, inv, h);
    check("s_cycle_data", d, 64'd104);
    csr_read(12'h306, 2'b01, d, inv, h);
    check("s_mcounteren_inv", inv, 1'b1);
    check("s_mcounteren_data", d, 64'd0);

    csr_addr = 12'hB00; data_in = 64'd0; priv_level = 2'b00; write = 1'b1;
    #2;
    check("u_write_b00_inv", invalid, 1'b1);
    tick();
    csr_addr = 12'hC00; priv_level = 2'b11;
    #2;
    check("m_write_c00_inv", invalid, 1'b1);
    tick();
    write = 1'b0;
    csr_read(12'hB00, 2'b11, d, inv, h);
    check("mcycle_unchanged", d, 64'd106);

    csr_write(12'h306, 64'hFFFF_FFFF);
    csr_read(12'h306, 2'b11, d, inv, h);
    check("mcounteren_mask", d, 64'h7F);
    csr_write(12'h320, 64'hFFFF_FFFF);
    csr_read(12'h320, 2'b11, d, inv, h);
    check("mcountinhibit_mask", d, 64'h7D);
    csr_write(12'h320, 64'h0);

    csr_write(12'hB03, 64'hFFFF_FFFF);
    events = 8'h02;
    tick();
    check("lcof_before_rst", lcof_irq, 1'b1);
    retire = 1'b1; time_tick = 1'b1;
    csr_addr = 12'hB02; data_in = 64'd77; write = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; write = 1'b0; retire = 1'b0; time_tick = 1'b0; events = 8'h00;
    check("lcof_rst_mid", lcof_irq, 1'b0);
    csr_read(12'hB00, 2'b11, d, inv, h);
    check("rst_mcycle", d, 64'd0);
    csr_read(12'hB02, 2'b11, d, inv, h);
    check("rst_minstret", d, 64'd0);
    csr_read(12'hC01, 2'b11, d, inv, h);
    check("rst_time", d, 64'd0);
    csr_read(12'hB03, 2'b11, d, inv, h);
    check("rst_hpm3", d, 64'd0);
    csr_read(12'h323, 2'b11, d, inv, h);
    check("rst_mhpmevent3", d, 64'd0);
    csr_read(12'h306, 2'b11, d, inv, h);
    check("rst_mcounteren", d, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
